// File: rtl/demux1_4_pkg.sv
// Shared definitions for the demux1_4 stream demultiplexer and its lanes.
package demux1_4_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } lane_state_e;

endpackage

// File: rtl/demux1_4_lane.sv
// One-entry registered output slot with valid/ready handshake.
// Optional per-lane drain counter built when DEMUX_BEAT_CNT_EN is defined.
module demux1_4_lane
  import demux1_4_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     din,
  input  logic             ready,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic             lane_ok_c
`ifdef DEMUX_BEAT_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt
`endif
);

  lane_state_e state_q;
  lane_state_e state_d;
  logic        drain;

  assign valid     = (state_q == ST_FULL);
  assign drain     = valid & ready;
  assign lane_ok_c = ~valid | ready;

  // Lane state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: a load always leaves the slot full, a lone drain empties it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load)           state_d = ST_FULL;
      ST_FULL:  if (drain && !load) state_d = ST_EMPTY;
      default:                      state_d = ST_EMPTY;
    endcase
  end

  // Payload register; holds the last loaded value while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data <= '0;
    else if (load) data <= din;
  end

`ifdef DEMUX_BEAT_CNT_EN
  // Drain counter; clear wins over a coincident increment, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (drain)   cnt <= cnt + CNT_W'(1);
  end
`endif

endmodule

// File: rtl/demux1_4.sv
// 1-to-4 stream demultiplexer with unicast/broadcast routing.
// Optional per-lane beat counters are enabled by the DEMUX_BEAT_CNT_EN macro.
module demux1_4
  import demux1_4_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*W-1:0]     out_data
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] beat_cnt,
  input  logic                   cnt_clr
`endif
);

  logic [N_OUT-1:0] lane_ok;
  logic [N_OUT-1:0] load;
  logic             accept;

  // Ready mux: selected lane for unicast, all lanes for broadcast
  always_comb begin
    in_ready = lane_ok[in_sel];
    if (in_bcast) in_ready = &lane_ok;
  end

  assign accept = in_valid & in_ready;

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    assign load[i] = accept & (in_bcast | (in_sel == SEL_W'(i)));

    demux1_4_lane #(.W(W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .din       (in_data),
      .ready     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i*W +: W]),
      .lane_ok_c (lane_ok[i])
`ifdef DEMUX_BEAT_CNT_EN
      ,
      .cnt_clr   (cnt_clr),
      .cnt       (beat_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_demux1_4.sv
// Self-checking bench for demux1_4 against a lane-array reference model.
// Counter checks are included when DEMUX_BEAT_CNT_EN is defined.
module tb_demux1_4;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_bcast;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic           cnt_clr;
`ifdef DEMUX_BEAT_CNT_EN
  logic [31:0]    beat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: per lane "holds a beat" flag, held payload, drain count
  bit         m_full [4];
  logic [7:0] m_data [4];
  logic [7:0] m_cnt  [4];

  demux1_4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .beat_cnt  (beat_cnt),
    .cnt_clr   (cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic exp_ready();
    bit all_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (m_full[i] && !out_ready[i]) all_ok = 1'b0;
    if (in_bcast) return all_ok;
    return !m_full[in_sel] || out_ready[in_sel];
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic [4*W-1:0] exp_data();
    logic [4*W-1:0] d;
    for (int i = 0; i < 4; i++) d[i*W +: W] = m_data[i];
    return d;
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] c;
    for (int i = 0; i < 4; i++) c[i*8 +: 8] = m_cnt[i];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
      m_cnt[i]  = '0;
    end
  endtask

  // Apply the current inputs to the model, then advance one clock
  task automatic tick();
    bit acc;
    bit drained;
    acc = in_valid && exp_ready();
    for (int i = 0; i < 4; i++) begin
      drained = m_full[i] && out_ready[i];
      if (acc && (in_bcast || in_sel == 2'(i))) begin
        m_full[i] = 1'b1;
        m_data[i] = in_data;
      end else if (drained) begin
        m_full[i] = 1'b0;
      end
`ifdef DEMUX_BEAT_CNT_EN
      if (cnt_clr)      m_cnt[i] = '0;
      else if (drained) m_cnt[i] = m_cnt[i] + 8'd1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input bit b,
                       input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_bcast  = b;
    in_data   = d;
    out_ready = r;
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0000);
    end
    total++;
    if (out_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", out_data);
    end
`ifdef DEMUX_BEAT_CNT_EN
    total++;
    if (beat_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_cnt got=%h exp=0", beat_cnt);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unicast();
    drive(1'b1, 2'd2, 1'b0, 8'hA5, 4'b1111);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL uni_ready got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b0100) begin
      bad++; $display("FAIL uni_valid got=%b exp=0100", out_valid);
    end
    total++;
    if (out_data !== {8'h00, 8'hA5, 8'h00, 8'h00}) begin
      bad++; $display("FAIL uni_data got=%h exp=00a50000", out_data);
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 2'd1, 1'b0, 8'h11, 4'b1101);
    tick();
    drive(1'b1, 2'd1, 1'b0, 8'h22, 4'b1101);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_ready got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h11) begin
      bad++; $display("FAIL stall_hold got=%b/%h exp=1/11", out_valid[1], out_data[15:8]);
    end
    drive(1'b1, 2'd1, 1'b0, 8'h22, 4'b1111);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release_ready got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h22) begin
      bad++; $display("FAIL stall_swap got=%b/%h exp=0010/22", out_valid, out_data[15:8]);
    end
    drive(1'b0, 2'd1, 1'b0, 8'h00, 4'b1111);
    tick();
    total++;
    if (out_valid !== 4'b0000 || out_data[15:8] !== 8'h22) begin
      bad++; $display("FAIL stall_drain got=%b/%h exp=0000/22", out_valid, out_data[15:8]);
    end
  endtask

  task automatic test_bcast_block();
    drive(1'b1, 2'd3, 1'b0, 8'h33, 4'b0111);
    tick();
    drive(1'b1, 2'd0, 1'b1, 8'h7E, 4'b0111);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bcast_block_ready got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b1000 || out_data !== exp_data()) begin
      bad++; $display("FAIL bcast_noload got=%b/%h exp=1000/%h", out_valid, out_data, exp_data());
    end
    drive(1'b1, 2'd1, 1'b1, 8'h7E, 4'b1111);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bcast_release_ready got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b1111 || out_data !== {4{8'h7E}}) begin
      bad++; $display("FAIL bcast_all got=%b/%h exp=1111/7e7e7e7e", out_valid, out_data);
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] sent [$];
    logic [7:0] d;
    cnt_clr = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    tick();
    cnt_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      sent.push_back(d);
      drive(1'b1, 2'd0, 1'b0, d, 4'b1111);
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_ready beat=%0d got=%b exp=1", k, in_ready);
      end
      tick();
      total++;
      if (out_valid[0] !== 1'b1 || out_data[7:0] !== sent.pop_front()) begin
        bad++; $display("FAIL stream_beat beat=%0d got=%b/%h exp=1/%h", k, out_valid[0], out_data[7:0], d);
      end
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    tick();
`ifdef DEMUX_BEAT_CNT_EN
    total++;
    if (beat_cnt[7:0] !== 8'd10) begin
      bad++; $display("FAIL stream_cnt got=%0d exp=10", beat_cnt[7:0]);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom), 4'($urandom));
      total++;
      if (in_ready !== exp_ready()) begin
        bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", k, in_ready, exp_ready());
      end
      tick();
      total++;
      if (out_valid !== exp_valid() || out_data !== exp_data()) begin
        bad++; $display("FAIL rand_out cyc=%0d got=%b/%h exp=%b/%h", k, out_valid, out_data, exp_valid(), exp_data());
      end
`ifdef DEMUX_BEAT_CNT_EN
      total++;
      if (beat_cnt !== exp_cnt()) begin
        bad++; $display("FAIL rand_cnt cyc=%0d got=%h exp=%h", k, beat_cnt, exp_cnt());
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd0, 1'b0, 8'hC0, 4'b0000);
    tick();
    drive(1'b1, 2'd2, 1'b0, 8'hC2, 4'b0000);
    tick();
    total++;
    if (out_valid !== 4'b0101) begin
      bad++; $display("FAIL mid_prefill got=%b exp=0101", out_valid);
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (out_valid !== 4'b0000 || out_data !== '0) begin
      bad++; $display("FAIL mid_reset_now got=%b/%h exp=0000/0", out_valid, out_data);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 4'b0000 || out_data !== '0) begin
      bad++; $display("FAIL mid_reset_edge got=%b/%h exp=0000/0", out_valid, out_data);
    end
`ifdef DEMUX_BEAT_CNT_EN
    total++;
    if (beat_cnt !== 32'd0) begin
      bad++; $display("FAIL mid_reset_cnt got=%h exp=0", beat_cnt);
    end
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef DEMUX_BEAT_CNT_EN
  task automatic test_cnt_wrap();
    cnt_clr = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    tick();
    cnt_clr = 1'b0;
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 2'd1, 1'b0, 8'(k), 4'b1111);
      tick();
    end
    drive(1'b0, 2'd1, 1'b0, 8'h00, 4'b1111);
    tick();
    total++;
    if (beat_cnt[15:8] !== 8'd0 || beat_cnt !== exp_cnt()) begin
      bad++; $display("FAIL cnt_wrap got=%h exp=%h", beat_cnt, exp_cnt());
    end
    drive(1'b1, 2'd1, 1'b0, 8'h5A, 4'b1111);
    tick();
    cnt_clr = 1'b1;
    drive(1'b0, 2'd1, 1'b0, 8'h00, 4'b1111);
    tick();
    cnt_clr = 1'b0;
    total++;
    if (beat_cnt !== 32'd0) begin
      bad++; $display("FAIL cnt_clr_drain got=%h exp=0", beat_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unicast();
    test_stall();
    test_bcast_block();
    test_stream();
    test_random();
    test_reset_mid();
`ifdef DEMUX_BEAT_CNT_EN
    test_cnt_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
